fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_ctrl_ptr_cnt.sv | 33 +++
 rtl/fifo_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO sizing constants for the controller and the memory wrapper.
// MEM_SIZE must be a power of two; PTR_L is log2(MEM_SIZE).
package fifo_pkg;
  localparam int DEF_MEM_SIZE = 8;
  localparam int DEF_PTR_L    = 3;
endpackage

// File: rtl/fifo_ctrl_ptr_cnt.sv
// ptr_cnt: modulo-2**PTR_L pointer incrementer (used for write and read side).
// Ports:
//   clk, reset : clock and synchronous active-high reset (pointer -> 0)
//   inc        : advance the pointer on this edge
//   ptr        : current pointer value
module ptr_cnt
  import fifo_pkg::*;
#(
  parameter int PTR_L = DEF_PTR_L
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_L-1:0] ptr
);

  logic [PTR_L-1:0] ptr_q;
  logic [PTR_L-1:0] ptr_d;

  // Depth is a power of two, so natural binary overflow gives the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + {{(PTR_L-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller driving an external memory.
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   push_req, pop_req      : write / read requests
//   af_thr, ae_thr         : live almost-full / almost-empty thresholds
//   push, pop              : accepted write / read strobes to the memory
//   wr_ptr, rd_ptr         : memory write / read addresses
//   count                  : occupancy 0..MEM_SIZE
//   full, empty            : occupancy flags
//   almost_full/empty      : threshold flags
//   overflow_err/underflow_err : sticky rejected-request flags
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int PTR_L    = DEF_PTR_L
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [PTR_L:0]   af_thr,
  input  logic [PTR_L:0]   ae_thr,
  output logic             push,
  output logic             pop,
  output logic [PTR_L-1:0] wr_ptr,
  output logic [PTR_L-1:0] rd_ptr,
  output logic [PTR_L:0]   count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [PTR_L:0] FULL_CNT = (PTR_L+1)'(MEM_SIZE);
  localparam logic [PTR_L:0] ONE_CNT  = (PTR_L+1)'(1);

  logic [PTR_L:0] count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // No fall-through: a pop at empty is refused even alongside a push.
  // A push at full is allowed only when a pop frees the slot in the same cycle;
  // the memory reads the old word before the edge overwrites it.
  assign pop  = !reset && pop_req && !empty;
  assign push = !reset && push_req && (!full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push_req & ~push);
    unf_d = unf_q | (pop_req & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  ptr_cnt #(.PTR_L(PTR_L)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  ptr_cnt #(.PTR_L(PTR_L)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  assign count         = count_q;
  assign almost_full   = (count_q >= af_thr);
  assign almost_empty  = (count_q <= ae_thr);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule
